serial_adder_ctrl: RTL and testbench

// - Sequencer for the bit-serial adder datapath: two 8-bit LSB-first operand shift registers feeding a 1-bit full adder.
// - Issues parallel-load and shift-enable to both operand registers and holds the carry flop between bit slices.
// - Collects sum bits into a parallel result register; start/busy/done handshake towards the top-level.

---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/serial_bit_counter.sv | 33 +++
 rtl/serial_adder_ctrl.sv | 139 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_adder_pkg;

  // Default operand/result width in bits.
  localparam int WIDTH_DEFAULT = 8;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bit-counter width: must be able to hold WIDTH-1.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Down-counter tracking the remaining bit slices of one serial addition.
// Latency: zero_o reflects the registered count (one cycle after load/decrement).
// Backpressure: none; load has priority over decrement, holds at zero.
module serial_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  // Load the slice count, then count down once per shifted bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - ONE;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Sequencer for a bit-serial LSB-first adder: load, WIDTH shift slices, done pulse.
// Latency: start sampled at edge N -> load N+1, shifts N+2..N+1+WIDTH, done N+2+WIDTH.
// Backpressure: start ignored (not queued) outside IDLE; abort returns to IDLE.
// Optional subtract mode under macro SERIAL_ADDER_SUB_EN (adds sub_i / b_inv_o).
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int  WIDTH = WIDTH_DEFAULT,
  localparam int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_i,
  output logic             b_inv_o,
`endif
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             sum_bit_i,
  input  logic             cout_bit_i,
  output logic             load_o,
  output logic             shift_en_o,
  output logic             carry_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  state_t           state_q, state_d;
  logic             cnt_zero;
  logic             start_acc;
  logic             carry_init;
  logic             carry_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             last_slice;

  assign start_acc  = (state_q == IDLE) && start_i;
  assign last_slice = (state_q == SHIFT) && !abort_i && cnt_zero;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;

  // Remember the operation for the whole run; the carry seed is the +1 of two's complement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if (start_acc) begin
      sub_q <= sub_i;
    end
  end

  assign carry_init = sub_i;
  assign b_inv_o    = sub_q && busy_o;
`else
  assign carry_init = 1'b0;
`endif

  serial_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (state_q == LOAD),
    .dec_i  (state_q == SHIFT),
    .zero_o (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and strobes; strobes decode the state register only, so no input-to-output path.
  always_comb begin
    state_d    = state_q;
    load_o     = 1'b0;
    shift_en_o = 1'b0;
    done_o     = 1'b0;
    busy_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = LOAD;
      end
      LOAD: begin
        load_o  = 1'b1;
        busy_o  = 1'b1;
        state_d = abort_i ? IDLE : SHIFT;
      end
      SHIFT: begin
        shift_en_o = 1'b1;
        busy_o     = 1'b1;
        if (abort_i)       state_d = IDLE;
        else if (cnt_zero) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Carry flop and sum collector: seeded on accept, one slice per SHIFT edge unless aborted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q  <= 1'b0;
      result_q <= '0;
    end else if (start_acc) begin
      carry_q <= carry_init;
    end else if ((state_q == SHIFT) && !abort_i) begin
      carry_q  <= cout_bit_i;
      result_q <= {sum_bit_i, result_q[WIDTH-1:1]};
    end
  end

  // Publish the result on the edge entering DONE, folding in the final slice so it is valid with done_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (last_slice) begin
      sum_q  <= {sum_bit_i, result_q[WIDTH-1:1]};
      cout_q <= cout_bit_i;
    end
  end

  assign carry_o = carry_q;
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: models operand shift registers and the full adder around the DUT,
// scoreboards each accepted start against arithmetic expectations and checks carry per slice.
// Subtract cases are exercised when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic         abort_i;
  logic         sum_bit_i;
  logic         cout_bit_i;
  logic         load_o;
  logic         shift_en_o;
  logic         carry_o;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] sum_o;
  logic         cout_o;
  logic         sub_i;
  logic         b_inv_o;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_i      (sub_i),
    .b_inv_o    (b_inv_o),
`endif
    .start_i    (start_i),
    .abort_i    (abort_i),
    .sum_bit_i  (sum_bit_i),
    .cout_bit_i (cout_bit_i),
    .load_o     (load_o),
    .shift_en_o (shift_en_o),
    .carry_o    (carry_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .sum_o      (sum_o),
    .cout_o     (cout_o)
  );

`ifndef SERIAL_ADDER_SUB_EN
  assign b_inv_o = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         ends_done;
    logic [W-1:0] sum;
    logic         cout;
    int           done_cyc;
  } txn_t;

  txn_t         q[$];
  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  int           sidx  = 0;
  logic         prev_busy = 1'b0;
  logic [W-1:0] a_cur, b_cur, a_sr, b_sr;
  logic [W-1:0] last_sum;
  logic         last_cout;
  logic         b_eff;

  always @(posedge clk) cyc <= cyc + 1;

  // Operand shift registers driven by the DUT strobes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
    end else if (load_o) begin
      a_sr <= a_cur;
      b_sr <= b_cur;
    end else if (shift_en_o) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
    end
  end

  // 1-bit full adder.
  always_comb begin
    b_eff      = b_sr[0] ^ b_inv_o;
    sum_bit_i  = a_sr[0] ^ b_eff ^ carry_o;
    cout_bit_i = (a_sr[0] & b_eff) | (a_sr[0] & carry_o) | (b_eff & carry_o);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                              input logic ends_done, input int done_cyc);
    txn_t       t;
    logic [W:0] s;
    if (sub) s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else     s = {1'b0, a} + {1'b0, b};
    t.a = a; t.b = b; t.sub = sub; t.ends_done = ends_done;
    t.sum = s[W-1:0]; t.cout = s[W]; t.done_cyc = done_cyc;
    return t;
  endfunction

  // Carry into bit k = overflow of the low k bits of the operation.
  function automatic int exp_carry(input txn_t t, input int k);
    logic [W-1:0] nb;
    int m, ai, bx;
    nb = ~t.b;
    m  = (1 << k) - 1;
    ai = int'(t.a);
    bx = t.sub ? int'(nb) : int'(t.b);
    return (((ai & m) + (bx & m) + int'(t.sub)) >> k) & 1;
  endfunction

  // Monitor: checks per-slice carry, done results/timing, and runs that end without done.
  always @(negedge clk) begin
    txn_t t;
    if (load_o) begin
      chk("load_shift_excl", int'(shift_en_o), 0);
      sidx = 0;
    end
    if (shift_en_o) begin
      if (q.size() == 0) chk("shift_without_txn", int'(shift_en_o), 0);
      else chk($sformatf("carry_in_bit%0d", sidx), int'(carry_o), exp_carry(q[0], sidx));
      sidx++;
    end
    if (done_o) begin
      if (q.size() == 0) begin
        chk("unexpected_done", int'(done_o), 0);
      end else begin
        t = q.pop_front();
        chk("done_expected", int'(done_o), int'(t.ends_done));
        chk($sformatf("sum_%0h_%0h_s%0d", t.a, t.b, t.sub), int'(sum_o), int'(t.sum));
        chk($sformatf("cout_%0h_%0h_s%0d", t.a, t.b, t.sub), int'(cout_o), int'(t.cout));
        chk("done_cycle", cyc, t.done_cyc);
      end
    end else if (prev_busy && !busy_o && q.size() > 0) begin
      t = q.pop_front();
      chk("end_without_done", int'(done_o), int'(t.ends_done));
    end
    prev_busy = busy_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_o || done_o) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) chk("idle_timeout", int'(busy_o | done_o), 0);
  endtask

  // Present start for one cycle from IDLE; returns one edge later (DUT in LOAD).
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic ends_done, input logic with_abort);
    txn_t t;
    wait_idle();
    a_cur   = a;
    b_cur   = b;
    sub_i   = sub;
    start_i = 1'b1;
    abort_i = with_abort;
    t = mk(a, b, sub, ends_done, cyc + W + 2);
    q.push_back(t);
    if (ends_done) begin
      last_sum  = t.sum;
      last_cout = t.cout;
    end
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    sub_i   = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_load"},  int'(load_o), 0);
    chk({tag, "_shift"}, int'(shift_en_o), 0);
    chk({tag, "_busy"},  int'(busy_o), 0);
    chk({tag, "_done"},  int'(done_o), 0);
    chk({tag, "_carry"}, int'(carry_o), 0);
    chk({tag, "_sum"},   int'(sum_o), 0);
    chk({tag, "_cout"},  int'(cout_o), 0);
    chk({tag, "_binv"},  int'(b_inv_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic sub_r;
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; sub_i = 1'b0;
    a_cur = '0; b_cur = '0; last_sum = '0; last_cout = 1'b0;
    repeat (2) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Directed additions.
    issue(8'h5A, 8'h3C, 1'b0, 1'b1, 1'b0);
    issue(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
    // Back-to-back: issue waits only for the IDLE cycle after DONE.
    issue(8'h80, 8'h80, 1'b0, 1'b1, 1'b0);
    issue(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // Start pulsed mid-SHIFT must be ignored.
    issue(8'h12, 8'h34, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;

    // Abort during the 4th SHIFT cycle.
    issue(8'hA5, 8'h5A, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_done", int'(done_o), 0);
    chk("abort_sum_held", int'(sum_o), int'(last_sum));
    chk("abort_cout_held", int'(cout_o), int'(last_cout));
    repeat (3) tick();

    // Start together with abort in IDLE: start wins.
    issue(8'h7F, 8'h01, 1'b0, 1'b1, 1'b1);

    // Reset asserted during SHIFT cycle 3.
    issue(8'hC3, 8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    last_sum  = '0;
    last_cout = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    issue(8'h11, 8'hEF, 1'b0, 1'b1, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    issue(8'h10, 8'h01, 1'b1, 1'b1, 1'b0);
    tick();
    chk("b_inv_busy", int'(b_inv_o), 1);
    issue(8'h01, 8'h02, 1'b1, 1'b1, 1'b0);
`endif

    // Randomised operands, back-to-back.
    for (int i = 0; i < 24; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
      sub_r = 1'($urandom_range(0, 1));
`else
      sub_r = 1'b0;
`endif
      issue(W'($urandom), W'($urandom), sub_r, 1'b1, 1'b0);
    end

    wait_idle();
    repeat (3) tick();
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
